// File: rtl/packet_merge_arbiter.sv
// Merges CHANNEL_NUMBER AXI-Stream inputs into one registered output. Round-robin
// arbitration happens at packet granularity: a grant lasts from the header beat to TLAST.
module packet_merge_arbiter #(
  parameter int DATA_WIDTH           = 32,
  parameter int ID_WIDTH             = 4,
  parameter int DEST_WIDTH           = 4,
  parameter int USER_WIDTH           = 4,
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] i_in_tdata,
  input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0]   i_in_tid,
  input  logic [CHANNEL_NUMBER*DEST_WIDTH-1:0] i_in_tdest,
  input  logic [CHANNEL_NUMBER*USER_WIDTH-1:0] i_in_tuser,
  input  logic [CHANNEL_NUMBER-1:0]            i_in_tlast,
  input  logic [CHANNEL_NUMBER-1:0]            i_in_valid,
  output logic [CHANNEL_NUMBER-1:0]            o_in_ready,
  output logic [DATA_WIDTH-1:0]                o_out_tdata,
  output logic [ID_WIDTH-1:0]                  o_out_tid,
  output logic [DEST_WIDTH-1:0]                o_out_tdest,
  output logic [USER_WIDTH-1:0]                o_out_tuser,
  output logic                                 o_out_tlast,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic                                 o_busy,
  output logic [CHANNEL_NUMBER_WIDTH-1:0]      o_grant_idx,
  output logic                                 o_state,
  output logic [CHANNEL_NUMBER_WIDTH-1:0]      o_rr_ptr
);

  localparam int CW = CHANNEL_NUMBER_WIDTH;

  // Handshake: a beat moves on input i in any cycle where i_in_valid[i] && o_in_ready[i];
  // the output beat moves when o_out_valid && i_out_ready. Valid never waits on ready.
  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_rr_ptr;
  logic [CW-1:0]           r_grant_idx;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_tdata;
  logic [ID_WIDTH-1:0]     r_out_tid;
  logic [DEST_WIDTH-1:0]   r_out_tdest;
  logic [USER_WIDTH-1:0]   r_out_tuser;
  logic                    r_out_tlast;

  logic                      w_slot_free;
  logic [CHANNEL_NUMBER-1:0] w_cand;
  logic                      w_win_found;
  logic [CW-1:0]             w_winner;
  logic [CW-1:0]             w_sel;
  logic [CHANNEL_NUMBER-1:0] w_ready;
  logic                      w_accept;
  logic [DATA_WIDTH-1:0]     w_sel_tdata;
  logic [ID_WIDTH-1:0]       w_sel_tid;
  logic [DEST_WIDTH-1:0]     w_sel_tdest;
  logic [USER_WIDTH-1:0]     w_sel_tuser;
  logic                      w_sel_tlast;

  assign w_slot_free = !r_out_valid || i_out_ready;

  always_comb begin
    w_cand = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      w_cand[i] = i_in_valid[i] && (i_in_tid[i*ID_WIDTH +: ID_WIDTH] == ROUTING_HEADER);
    end
  end

  // Walk from farthest to nearest so the candidate closest after rr_ptr is written last.
  always_comb begin
    w_win_found = 1'b0;
    w_winner    = '0;
    for (int k = CHANNEL_NUMBER; k >= 1; k--) begin
      if (w_cand[(int'(r_rr_ptr) + k) % CHANNEL_NUMBER]) begin
        w_win_found = 1'b1;
        w_winner    = CW'((int'(r_rr_ptr) + k) % CHANNEL_NUMBER);
      end
    end
  end

  always_comb begin
    w_sel   = r_grant_idx;
    w_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_sel             = w_winner;
          w_ready[w_winner] = w_slot_free;
        end
      end
      S_LOCKED: w_ready[r_grant_idx] = w_slot_free;
      default: ;
    endcase
  end

  assign w_accept    = |(w_ready & i_in_valid);
  assign w_sel_tdata = i_in_tdata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_tid   = i_in_tid[int'(w_sel)*ID_WIDTH +: ID_WIDTH];
  assign w_sel_tdest = i_in_tdest[int'(w_sel)*DEST_WIDTH +: DEST_WIDTH];
  assign w_sel_tuser = i_in_tuser[int'(w_sel)*USER_WIDTH +: USER_WIDTH];
  assign w_sel_tlast = i_in_tlast[w_sel];

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (r_state == S_IDLE && !w_sel_tlast) begin
        w_state_nxt = S_LOCKED;
      end else if (r_state == S_LOCKED && w_sel_tlast) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= CW'(CHANNEL_NUMBER - 1);
      r_grant_idx <= '0;
      r_out_valid <= 1'b0;
      r_out_tdata <= '0;
      r_out_tid   <= '0;
      r_out_tdest <= '0;
      r_out_tuser <= '0;
      r_out_tlast <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_tdata <= w_sel_tdata;
        r_out_tid   <= w_sel_tid;
        r_out_tdest <= w_sel_tdest;
        r_out_tuser <= w_sel_tuser;
        r_out_tlast <= w_sel_tlast;
        if (r_state == S_IDLE) begin
          r_grant_idx <= w_sel;
          if (w_sel_tlast) r_rr_ptr <= w_sel;
        end else if (w_sel_tlast) begin
          r_rr_ptr <= r_grant_idx;
        end
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready  = w_ready;
  assign o_out_tdata = r_out_tdata;
  assign o_out_tid   = r_out_tid;
  assign o_out_tdest = r_out_tdest;
  assign o_out_tuser = r_out_tuser;
  assign o_out_tlast = r_out_tlast;
  assign o_out_valid = r_out_valid;
  assign o_busy      = (r_state == S_LOCKED);
  assign o_grant_idx = r_grant_idx;
  assign o_state     = r_state;
  assign o_rr_ptr    = r_rr_ptr;

endmodule

// File: tb/tb_packet_merge_arbiter.sv
// Directed bench for packet_merge_arbiter: per-input beat drivers, an expected-beat
// queue checked at the output, and cycle-exact checks of grant/busy/ready.
module tb_packet_merge_arbiter;

  localparam int CH = 5;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int TW = 4;
  localparam int UW = 4;
  localparam int CW = 3;
  localparam logic [IW-1:0] HDR = 4'h0;

  logic              clk;
  logic              rst;
  logic [CH*DW-1:0]  i_in_tdata;
  logic [CH*IW-1:0]  i_in_tid;
  logic [CH*TW-1:0]  i_in_tdest;
  logic [CH*UW-1:0]  i_in_tuser;
  logic [CH-1:0]     i_in_tlast;
  logic [CH-1:0]     i_in_valid;
  logic [CH-1:0]     o_in_ready;
  logic [DW-1:0]     o_out_tdata;
  logic [IW-1:0]     o_out_tid;
  logic [TW-1:0]     o_out_tdest;
  logic [UW-1:0]     o_out_tuser;
  logic              o_out_tlast;
  logic              o_out_valid;
  logic              i_out_ready;
  logic              o_busy;
  logic [CW-1:0]     o_grant_idx;
  logic              o_state;
  logic [CW-1:0]     o_rr_ptr;

  packet_merge_arbiter #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(TW), .USER_WIDTH(UW),
    .CHANNEL_NUMBER(CH), .CHANNEL_NUMBER_WIDTH(CW), .ROUTING_HEADER(HDR)
  ) dut (
    .clk(clk), .rst(rst),
    .i_in_tdata(i_in_tdata), .i_in_tid(i_in_tid), .i_in_tdest(i_in_tdest),
    .i_in_tuser(i_in_tuser), .i_in_tlast(i_in_tlast), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready),
    .o_out_tdata(o_out_tdata), .o_out_tid(o_out_tid), .o_out_tdest(o_out_tdest),
    .o_out_tuser(o_out_tuser), .o_out_tlast(o_out_tlast), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_busy(o_busy), .o_grant_idx(o_grant_idx),
    .o_state(o_state), .o_rr_ptr(o_rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // expected output beats: {tdest, tlast, tdata}
  logic [TW+DW:0] exp_q[$];

  // per-input beat FIFOs
  logic [DW-1:0] dm_data[CH][16];
  logic [IW-1:0] dm_tid[CH][16];
  logic          dm_last[CH][16];
  int            dm_wr[CH];
  int            dm_rd[CH];
  logic [CH-1:0] acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int ch, input int p, input int b);
    return 32'hA000_0000 | DW'(ch << 16) | DW'(p << 8) | DW'(b);
  endfunction

  task automatic clear_drivers();
    for (int c = 0; c < CH; c++) begin
      dm_wr[c] = 0;
      dm_rd[c] = 0;
    end
    i_in_valid = '0;
    exp_q.delete();
  endtask

  // Queue a packet on input ch and its expected output beats (in expected grant order).
  task automatic push_pkt(input int ch, input int p, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      dm_data[ch][dm_wr[ch]] = mk(ch, p, b);
      dm_tid[ch][dm_wr[ch]]  = (b == 0) ? HDR : 4'h5;
      dm_last[ch][dm_wr[ch]] = (b == nbeats - 1);
      dm_wr[ch]++;
      exp_q.push_back({TW'(ch), (b == nbeats - 1), mk(ch, p, b)});
    end
  endtask

  // driver: record handshakes mid-cycle, advance heads just after the edge
  initial begin
    i_in_tdata = '0; i_in_tid = '0; i_in_tdest = '0; i_in_tuser = '0;
    i_in_tlast = '0; i_in_valid = '0;
    for (int c = 0; c < CH; c++) begin
      dm_wr[c] = 0;
      dm_rd[c] = 0;
    end
    forever begin
      @(negedge clk);
      acc = i_in_valid & o_in_ready;
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (acc[c] && dm_rd[c] < dm_wr[c]) dm_rd[c]++;
        if (dm_rd[c] < dm_wr[c]) begin
          i_in_valid[c]            = 1'b1;
          i_in_tdata[c*DW +: DW]   = dm_data[c][dm_rd[c]];
          i_in_tid[c*IW +: IW]     = dm_tid[c][dm_rd[c]];
          i_in_tlast[c]            = dm_last[c][dm_rd[c]];
          i_in_tdest[c*TW +: TW]   = TW'(c);
          i_in_tuser[c*UW +: UW]   = UW'(dm_rd[c]);
        end else begin
          i_in_valid[c] = 1'b0;
        end
      end
    end
  end

  // scoreboard: compare every output beat taken by downstream
  initial begin
    logic [TW+DW:0] e;
    forever begin
      @(negedge clk);
      if (!rst && o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {32'd0, o_out_tdata}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", {27'd0, o_out_tdest, o_out_tlast, o_out_tdata}, {27'd0, e});
        end
      end
    end
  end

  function automatic bit drivers_empty();
    for (int c = 0; c < CH; c++) if (dm_rd[c] != dm_wr[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 300; n++) begin
      if (exp_q.size() == 0 && drivers_empty()) break;
      @(negedge clk);
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_drivers();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset then idle
    @(negedge clk);
    check("rst_out_valid", 64'(o_out_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_in_ready", 64'(o_in_ready), 64'd0);
    check("rst_out_tdata", 64'(o_out_tdata), 64'd0);
    check("rst_grant", 64'(o_grant_idx), 64'd0);
    check("rst_rr_ptr", 64'(o_rr_ptr), 64'd4);

    // 2: simultaneous headers on in0 and in2, 3-beat packets
    push_pkt(0, 1, 3);
    push_pkt(2, 1, 3);
    @(negedge clk);
    check("t2_ready_c0", 64'(o_in_ready), 64'b00001);
    @(negedge clk);
    check("t2_busy_c1", 64'(o_busy), 64'd1);
    check("t2_grant_c1", 64'(o_grant_idx), 64'd0);
    repeat (2) @(negedge clk);
    check("t2_busy_c3", 64'(o_busy), 64'd0);
    check("t2_grant_c3", 64'(o_grant_idx), 64'd0);
    check("t2_ready_c3", 64'(o_in_ready), 64'b00100);
    @(negedge clk);
    check("t2_busy_c4", 64'(o_busy), 64'd1);
    check("t2_grant_c4", 64'(o_grant_idx), 64'd2);
    wait_drain("t2_drain");
    check("t2_busy_end", 64'(o_busy), 64'd0);
    check("t2_rr_end", 64'(o_rr_ptr), 64'd2);

    // 3: fairness and wrap, all inputs, two 2-beat packets each
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < CH; c++) push_pkt(c, p, 2);
    wait_drain("t3_drain");
    check("t3_grant_end", 64'(o_grant_idx), 64'd4);
    check("t3_rr_end", 64'(o_rr_ptr), 64'd4);

    // 4: backpressure mid-packet on in1, out_ready 1,0,0,1
    do_reset();
    push_pkt(1, 3, 4);
    @(posedge clk);
    @(posedge clk);
    #1 i_out_ready = 1'b0;
    @(negedge clk);
    check("t4_stall1_ready", 64'(o_in_ready), 64'd0);
    check("t4_stall1_data", 64'(o_out_tdata), 64'(mk(1, 3, 0)));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_stall2_ready", 64'(o_in_ready), 64'd0);
    check("t4_stall2_data", 64'(o_out_tdata), 64'(mk(1, 3, 0)));
    check("t4_stall2_valid", 64'(o_out_valid), 64'd1);
    @(posedge clk);
    #1 i_out_ready = 1'b1;
    @(negedge clk);
    check("t4_resume_ready", 64'(o_in_ready), 64'b00010);
    wait_drain("t4_drain");

    // 5: single-beat packet on in3, then header on in4 next cycle
    do_reset();
    push_pkt(3, 4, 1);
    @(negedge clk);
    check("t5_ready3", 64'(o_in_ready), 64'b01000);
    push_pkt(4, 4, 2);
    @(negedge clk);
    check("t5_busy_c1", 64'(o_busy), 64'd0);
    check("t5_rr_c1", 64'(o_rr_ptr), 64'd3);
    check("t5_grant_c1", 64'(o_grant_idx), 64'd3);
    check("t5_ready4", 64'(o_in_ready), 64'b10000);
    @(negedge clk);
    check("t5_busy_c2", 64'(o_busy), 64'd1);
    check("t5_grant_c2", 64'(o_grant_idx), 64'd4);
    wait_drain("t5_drain");

    // 6: reset asserted mid-packet on in0
    do_reset();
    push_pkt(0, 6, 4);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(o_out_valid), 64'd0);
    check("t6_async_busy", 64'(o_busy), 64'd0);
    check("t6_async_rr", 64'(o_rr_ptr), 64'd4);
    clear_drivers();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_pkt(0, 7, 4);
    @(negedge clk);
    check("t6_ready0", 64'(o_in_ready), 64'b00001);
    wait_drain("t6_drain");
    check("t6_grant_end", 64'(o_grant_idx), 64'd0);
    check("t6_busy_end", 64'(o_busy), 64'd0);
    check("t6_rr_end", 64'(o_rr_ptr), 64'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
